line_drawer: RTL

LINE_DRAWER -- requirements
Module: line_drawer

---
 rtl/line_pkg.sv | 28 ++
 rtl/line_drawer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/line_pkg.sv
// -----------------------------------------------------------------------------
// line_pkg
//   Shared constants for the Bresenham line drawer: screen size defaults,
//   coordinate and error-term widths, and the FSM state encoding.
// -----------------------------------------------------------------------------
package line_pkg;

    // Visible screen defaults (160x120 VGA adapter mode).
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    // Coordinate widths match the VGA adapter ports.
    localparam int X_W = 8;
    localparam int Y_W = 7;

    // err spans roughly [2*dy, 2*dx] = [-254, 510], so 10 signed bits hold it;
    // e2 = 2*err needs one more bit.
    localparam int ERR_W = 10;
    localparam int E2_W  = 11;

    // FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_INIT = 2'd1;
    localparam state_t S_DRAW = 2'd2;
    localparam state_t S_DONE = 2'd3;

endpackage : line_pkg

// File: rtl/line_drawer.sv
// -----------------------------------------------------------------------------
// line_drawer
//   Draws one line with Bresenham's algorithm, emitting one pixel per clock.
//
// Ports
//   CLOCK_50            sole clock, rising edge
//   resetn              asynchronous active-low reset
//   start               request to draw a line (accepted only in IDLE)
//   x0,y0,x1,y1         line endpoints (captured with start)
//   colour_in           line colour (captured with start)
//   x,y,colour          current pixel to the VGA adapter
//   plot                write strobe: DRAW cycle with an on-screen pixel
//   busy                high in INIT and DRAW
//   done                one-cycle pulse after the last pixel
//   dbg_state_o         current FSM state, for observation only
//
// Handshake: start is a level sampled on the rising edge only while the FSM is
// in IDLE; the request is accepted on that edge (busy rises the next cycle),
// endpoints/colour are captured then, and any start or endpoint change while
// busy or in DONE is ignored. done marks completion for exactly one cycle.
// -----------------------------------------------------------------------------
module line_drawer
    import line_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    input  logic [2:0]     colour_in,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           busy,
    output logic           done,
    output state_t         dbg_state_o
);

    localparam int XL_W = X_W + 1;
    localparam int YL_W = Y_W + 1;
    localparam logic [XL_W-1:0] X_LIM = XL_W'(SCREEN_W);
    localparam logic [YL_W-1:0] Y_LIM = YL_W'(SCREEN_H);
    localparam logic signed [ERR_W-1:0] ERR_ZERO = '0;

    state_t                   state_q,  state_d;
    logic [X_W-1:0]           x_q,      x_d;      // current point
    logic [Y_W-1:0]           y_q,      y_d;
    logic [X_W-1:0]           x1_q,     x1_d;     // captured end point
    logic [Y_W-1:0]           y1_q,     y1_d;
    logic [2:0]               col_q,    col_d;
    logic signed [ERR_W-1:0]  dx_q,     dx_d;     // +|x1-x0|
    logic signed [ERR_W-1:0]  dy_q,     dy_d;     // -|y1-y0|
    logic signed [ERR_W-1:0]  err_q,    err_d;
    logic                     sx_neg_q, sx_neg_d; // step direction: 1 = -1
    logic                     sy_neg_q, sy_neg_d;

    logic [X_W-1:0]           dx_abs;
    logic [Y_W-1:0]           dy_abs;
    logic signed [E2_W-1:0]   e2, dx_ext, dy_ext;
    logic                     step_x, step_y, at_end;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        col_d    = col_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;

        dx_abs = (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q);
        dy_abs = (y1_q >= y_q) ? (y1_q - y_q) : (y_q - y1_q);

        e2     = {err_q, 1'b0};
        dx_ext = {dx_q[ERR_W-1], dx_q};
        dy_ext = {dy_q[ERR_W-1], dy_q};
        step_x = (e2 >= dy_ext);
        step_y = (e2 <= dx_ext);
        at_end = (x_q == x1_q) && (y_q == y1_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // The start point goes straight into the current-point
                    // registers; INIT derives the deltas from them.
                    x_d     = x0;
                    y_d     = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    col_d   = colour_in;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                dx_d     = $signed({{(ERR_W-X_W){1'b0}}, dx_abs});
                dy_d     = -$signed({{(ERR_W-Y_W){1'b0}}, dy_abs});
                err_d    = $signed({{(ERR_W-X_W){1'b0}}, dx_abs})
                         - $signed({{(ERR_W-Y_W){1'b0}}, dy_abs});
                sx_neg_d = (x1_q < x_q);
                sy_neg_d = (y1_q < y_q);
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                if (at_end) begin
                    state_d = S_DONE;
                end else begin
                    // Both Bresenham steps may fire together; their err
                    // contributions are summed into one update.
                    err_d = err_q + (step_x ? dy_q : ERR_ZERO)
                                  + (step_y ? dx_q : ERR_ZERO);
                    if (step_x) x_d = sx_neg_q ? (x_q - 1'b1) : (x_q + 1'b1);
                    if (step_y) y_d = sy_neg_q ? (y_q - 1'b1) : (y_q + 1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            col_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            col_q    <= col_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    // Outputs decode registered state only, so reset clears them at once.
    assign x           = x_q;
    assign y           = y_q;
    assign colour      = col_q;
    assign plot        = (state_q == S_DRAW) &&
                         ({1'b0, x_q} < X_LIM) && ({1'b0, y_q} < Y_LIM);
    assign busy        = (state_q == S_INIT) || (state_q == S_DRAW);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule : line_drawer
